// File: rtl/cfgreg_pkg.sv
// Shared constants for the daisy-chained configuration-register bus.
// Message layout (MSB..LSB): addr | wr | payload.
package cfgreg_pkg;

  localparam int CFG_ADDR_SIZE    = 4;
  localparam int CFG_PAYLOAD_SIZE = 8;

  // Field offsets for the default sizes; the functions below give them for any payload width.
  localparam int CFG_WR_POS   = CFG_PAYLOAD_SIZE;
  localparam int CFG_ADDR_LSB = CFG_PAYLOAD_SIZE + 1;

  localparam logic [CFG_ADDR_SIZE-1:0] CFG_BCAST_ADDR = {CFG_ADDR_SIZE{1'b1}};

  function automatic int wr_pos(input int payload_size);
    return payload_size;
  endfunction

  function automatic int addr_lsb(input int payload_size);
    return payload_size + 1;
  endfunction

endpackage

// File: rtl/cfgreg_msg_decode.sv
// Combinational split of a bus message into addr / wr / payload,
// plus a flag that says whether the message targets this node.
module cfgreg_msg_decode
  import cfgreg_pkg::*;
#(
  parameter int                    ADDR_SIZE    = CFG_ADDR_SIZE,
  parameter int                    PAYLOAD_SIZE = CFG_PAYLOAD_SIZE,
  parameter logic [ADDR_SIZE-1:0]  ADDR         = '0
) (
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0] msg,
  output logic [ADDR_SIZE-1:0]            addr,
  output logic                            wr,
  output logic [PAYLOAD_SIZE-1:0]         payload,
  output logic                            match
);

  localparam int WR_POS   = wr_pos(PAYLOAD_SIZE);
  localparam int ADDR_LSB = addr_lsb(PAYLOAD_SIZE);

  always_comb begin
    addr    = msg[ADDR_LSB +: ADDR_SIZE];
    wr      = msg[WR_POS];
    payload = msg[PAYLOAD_SIZE-1:0];
    match   = (addr == ADDR);
  end

endmodule

// File: rtl/config_reg_node.sv
// One node of the daisy-chained configuration bus: owns one register at ADDR.
// Optional broadcast writes to the all-ones address when CFGREG_BCAST_EN is defined.
module config_reg_node
  import cfgreg_pkg::*;
#(
  parameter int                    ADDR_SIZE    = CFG_ADDR_SIZE,
  parameter int                    PAYLOAD_SIZE = CFG_PAYLOAD_SIZE,
  parameter logic [ADDR_SIZE-1:0]  ADDR         = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0] rec_msg,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0] send_msg
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;

  logic [ADDR_SIZE-1:0]    dec_addr;
  logic                    dec_wr;
  logic [PAYLOAD_SIZE-1:0] dec_payload;
  logic                    dec_match;

  logic [PAYLOAD_SIZE-1:0] cfg_d, cfg_q;
  logic [MSG_W-1:0]        send_msg_d, send_msg_q;

`ifdef CFGREG_BCAST_EN
  localparam logic [ADDR_SIZE-1:0] BCAST_ADDR = '1;

  // The all-ones address is reserved for broadcast, so no node may own it.
  if (ADDR == BCAST_ADDR) begin : g_bad_addr
    $error("config_reg_node: ADDR must not be the broadcast address when CFGREG_BCAST_EN is defined");
  end
`endif

  cfgreg_msg_decode #(
    .ADDR_SIZE    (ADDR_SIZE),
    .PAYLOAD_SIZE (PAYLOAD_SIZE),
    .ADDR         (ADDR)
  ) u_decode (
    .msg     (rec_msg),
    .addr    (dec_addr),
    .wr      (dec_wr),
    .payload (dec_payload),
    .match   (dec_match)
  );

  // A matched write echoes the freshly written value (write-through acknowledge).
  always_comb begin
    cfg_d      = cfg_q;
    send_msg_d = rec_msg;
    if (dec_match) begin
      if (dec_wr) begin
        cfg_d = dec_payload;
      end
      send_msg_d = {dec_addr, 1'b0, cfg_d};
    end
`ifdef CFGREG_BCAST_EN
    else if (dec_addr == BCAST_ADDR && dec_wr) begin
      cfg_d = dec_payload;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q      <= '0;
      send_msg_q <= '0;
    end else begin
      cfg_q      <= cfg_d;
      send_msg_q <= send_msg_d;
    end
  end

  assign send_msg = send_msg_q;

endmodule

// File: tb/tb_config_reg_node.sv
// Scoreboard bench for config_reg_node: directed plan followed by random traffic.
// Model and DUT both honour CFGREG_BCAST_EN when it is defined.
module tb_config_reg_node;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int MW = AW + PW + 1;
  localparam logic [AW-1:0] NODE_ADDR = 4'd0;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] rec_msg;
  logic [MW-1:0] send_msg;

  typedef struct {
    logic [MW-1:0] msg;
    int            due;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt  = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   model_cfg = 0;

  config_reg_node #(
    .ADDR_SIZE    (AW),
    .PAYLOAD_SIZE (PW),
    .ADDR         (NODE_ADDR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rec_msg  (rec_msg),
    .send_msg (send_msg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: send_msg got %b, expected %b", tag, act, exp);
    end
  endtask

  // Reference model: fields extracted with plain arithmetic on the message value.
  function automatic logic [MW-1:0] modelStep(input logic [MW-1:0] msg, input bit rst);
    int m, addr, wr, payload;
    m       = int'(msg);
    addr    = m >> (PW + 1);
    wr      = (m >> PW) % 2;
    payload = m % (1 << PW);
    if (rst) begin
      model_cfg = 0;
      return '0;
    end
    if (addr == int'(NODE_ADDR)) begin
      if (wr == 1) model_cfg = payload;
      return MW'((addr << (PW + 1)) + model_cfg);
    end
`ifdef CFGREG_BCAST_EN
    if (addr == (1 << AW) - 1 && wr == 1) model_cfg = payload;
`endif
    return msg;
  endfunction

  task automatic applyStimulus(input logic [MW-1:0] msg, input bit rst, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    rec_msg = msg;
    e.msg   = modelStep(msg, rst);
    e.due   = edge_cnt + 1;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      e = exp_q.pop_front();
      checkOutput(e.tag, send_msg, e.msg);
    end
  end

  initial begin
    logic [MW-1:0] m;
    bit            r;
    int            waited;
    reset   = 1'b1;
    rec_msg = '0;

    applyStimulus({4'b0000, 1'b1, 8'b11111111}, 1'b1, "reset_write_ignored");
    applyStimulus({4'b0000, 1'b0, 8'b00000000}, 1'b0, "read_after_reset");
    applyStimulus({4'b0000, 1'b1, 8'b01010101}, 1'b0, "matched_write");
    applyStimulus({4'b0000, 1'b0, 8'b01010101}, 1'b0, "matched_read");
    applyStimulus({4'b0000, 1'b0, 8'b11110000}, 1'b0, "read_payload_ignored");
    applyStimulus({4'b0101, 1'b1, 8'b01010101}, 1'b0, "unmatched_write_fwd");
    applyStimulus({4'b0000, 1'b0, 8'b00000000}, 1'b0, "read_after_unmatched");
    applyStimulus({4'b0101, 1'b0, 8'b01010101}, 1'b0, "unmatched_read_fwd");
    applyStimulus({4'b0000, 1'b1, 8'b00000011}, 1'b0, "b2b_write_1");
    applyStimulus({4'b0000, 1'b1, 8'b11000000}, 1'b0, "b2b_write_2");
    applyStimulus({4'b0000, 1'b0, 8'b00001111}, 1'b0, "read_last_wins");
    applyStimulus({4'b1111, 1'b1, 8'b10100101}, 1'b0, "allones_write");
    applyStimulus({4'b0000, 1'b0, 8'b00000000}, 1'b0, "read_after_allones");
    applyStimulus({4'b1111, 1'b0, 8'b00111100}, 1'b0, "allones_read");
    applyStimulus({4'b0000, 1'b1, 8'b00111100}, 1'b1, "midstream_reset");
    applyStimulus({4'b0000, 1'b0, 8'b00000000}, 1'b0, "read_after_midreset");

    for (int i = 0; i < 400; i++) begin
      m = MW'($urandom);
      if ($urandom_range(0, 2) == 0) m[MW-1 -: AW] = NODE_ADDR;
      r = ($urandom_range(0, 49) == 0);
      applyStimulus(m, r, "random");
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
